// File: rtl/rf_wb_scheduler_if.sv
// Write-channel, hazard-query, bank-port and status bundle for rf_wb_scheduler.
// The master side drives writes and read addresses; the slave side is the scheduler.
interface rf_wb_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             wv0_i;
    logic [4:0]       wa0_i;
    logic [WIDTH-1:0] wd0_i;
    logic             wv1_i;
    logic [4:0]       wa1_i;
    logic [WIDTH-1:0] wd1_i;
    logic             w_ready_o;

    logic [4:0]       ra0_i;
    logic [4:0]       ra1_i;
    logic [4:0]       ra2_i;
    logic [4:0]       ra3_i;
    logic [3:0]       rd_pending_o;

    logic             b0_we_o;
    logic [4:0]       b0_wa_o;
    logic [WIDTH-1:0] b0_wd_o;
    logic             b1_we_o;
    logic [4:0]       b1_wa_o;
    logic [WIDTH-1:0] b1_wd_o;

    logic             init_done_o;
    logic             idle_o;
    logic [15:0]      conflict_cnt_o;

    modport master (
        output wv0_i, wa0_i, wd0_i, wv1_i, wa1_i, wd1_i,
        output ra0_i, ra1_i, ra2_i, ra3_i,
        input  w_ready_o, rd_pending_o,
        input  b0_we_o, b0_wa_o, b0_wd_o, b1_we_o, b1_wa_o, b1_wd_o,
        input  init_done_o, idle_o, conflict_cnt_o
    );

    modport slave (
        input  wv0_i, wa0_i, wd0_i, wv1_i, wa1_i, wd1_i,
        input  ra0_i, ra1_i, ra2_i, ra3_i,
        output w_ready_o, rd_pending_o,
        output b0_we_o, b0_wa_o, b0_wd_o, b1_we_o, b1_wa_o, b1_wd_o,
        output init_done_o, idle_o, conflict_cnt_o
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register-file write-back scheduler: two write channels steered into even/odd banks,
// each bank with a 2-entry in-order queue, zero-latency bypass and a post-reset clear sweep.
module rf_wb_scheduler #(
    parameter int WIDTH  = 32,
    parameter int QDEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    rf_wb_scheduler_if.slave bus
);
    localparam logic [1:0] OCC_FULL = 2'(QDEPTH);

    typedef enum logic { S_INIT, S_RUN } state_t;
    typedef struct packed {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t      state;
    logic [3:0]  clr_cnt;
    logic [15:0] conflict_q;
    logic [1:0]  occ     [2];
    entry_t      q       [2][2];

    logic        run, ready, fire0, fire1, in0, in1, conflict;
    entry_t      ent     [2][3];
    logic [1:0]  n_ent   [2];
    logic [1:0]  occ_nxt [2];
    logic        issue   [2];
    logic [4:0]  ra      [4];

    assign ra = '{bus.ra0_i, bus.ra1_i, bus.ra2_i, bus.ra3_i};

    // Candidates per bank, oldest first: stored entries, then channel 0, then channel 1.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a default first,
        // so no path leaves a value held and no latch is inferred.
        run      = (state == S_RUN) && !rst;
        ready    = run && (occ[0] < OCC_FULL) && (occ[1] < OCC_FULL);
        fire0    = bus.wv0_i && ready;
        fire1    = bus.wv1_i && ready;
        in0      = fire0 && (bus.wa0_i != 5'd0);
        in1      = fire1 && (bus.wa1_i != 5'd0);
        conflict = in0 && in1 && (bus.wa0_i[0] == bus.wa1_i[0]);
        ent      = '{default: '0};
        n_ent    = '{default: '0};
        occ_nxt  = '{default: '0};
        issue    = '{default: 1'b0};
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 2; i++) begin
                if (2'(i) < occ[b]) begin
                    ent[b][n_ent[b]] = q[b][i];
                    n_ent[b]         = n_ent[b] + 2'd1;
                end
            end
            if (in0 && (bus.wa0_i[0] == 1'(b))) begin
                ent[b][n_ent[b]] = '{addr: bus.wa0_i, data: bus.wd0_i};
                n_ent[b]         = n_ent[b] + 2'd1;
            end
            if (in1 && (bus.wa1_i[0] == 1'(b))) begin
                ent[b][n_ent[b]] = '{addr: bus.wa1_i, data: bus.wd1_i};
                n_ent[b]         = n_ent[b] + 2'd1;
            end
            issue[b]   = run && (n_ent[b] != 2'd0);
            occ_nxt[b] = issue[b] ? n_ent[b] - 2'd1 : n_ent[b];
        end
    end

    always_comb begin
        bus.w_ready_o      = ready;
        bus.init_done_o    = run;
        bus.idle_o         = run && (occ[0] == 2'd0) && (occ[1] == 2'd0) && !issue[0] && !issue[1];
        bus.conflict_cnt_o = rst ? 16'd0 : conflict_q;
        bus.b0_we_o = 1'b0;
        bus.b0_wa_o = '0;
        bus.b0_wd_o = '0;
        bus.b1_we_o = 1'b0;
        bus.b1_wa_o = '0;
        bus.b1_wd_o = '0;
        if (!rst && state == S_INIT) begin
            bus.b0_we_o = 1'b1;
            bus.b0_wa_o = {clr_cnt, 1'b0};
            bus.b1_we_o = 1'b1;
            bus.b1_wa_o = {clr_cnt, 1'b1};
        end else begin
            if (issue[0]) begin
                bus.b0_we_o = 1'b1;
                bus.b0_wa_o = ent[0][0].addr;
                bus.b0_wd_o = ent[0][0].data;
            end
            if (issue[1]) begin
                bus.b1_we_o = 1'b1;
                bus.b1_wa_o = ent[1][0].addr;
                bus.b1_wd_o = ent[1][0].data;
            end
        end
    end

    // Hazard lookup sees only the registered queue, never this cycle's fired writes.
    always_comb begin
        bus.rd_pending_o = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 2; j++) begin
                    if (!rst && ra[i] != 5'd0 && 2'(j) < occ[b] && q[b][j].addr == ra[i])
                        bus.rd_pending_o[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            clr_cnt    <= 4'd0;
            conflict_q <= 16'd0;
            occ        <= '{default: 2'd0};
        end else begin
            case (state)
                S_INIT: begin
                    clr_cnt <= clr_cnt + 4'd1;
                    if (clr_cnt == 4'd15) state <= S_RUN;
                end
                default: begin
                    occ <= occ_nxt;
                    if (conflict && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
                end
            endcase
        end
    end

    // NOTE: queue payload has no reset; occ alone marks which slots are valid.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            q[b][0] <= ent[b][1];
            q[b][1] <= ent[b][2];
        end
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: clear sweep, bypass, same-bank ordering,
// back-pressure, r0 discard, reset flush and conflict-counter saturation.
module tb_rf_wb_scheduler;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rf_wb_scheduler_if #(.WIDTH(WIDTH)) bus ();

    rf_wb_scheduler #(.WIDTH(WIDTH), .QDEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.wv0_i = v0; bus.wa0_i = a0; bus.wd0_i = d0;
        bus.wv1_i = v1; bus.wa1_i = a1; bus.wd1_i = d1;
    endtask

    task automatic check_bank(input string tag, input logic we0, input logic [4:0] a0,
                              input logic [31:0] d0, input logic we1, input logic [4:0] a1,
                              input logic [31:0] d1);
        check({tag, "_b0we"}, 64'(bus.b0_we_o), 64'(we0));
        check({tag, "_b0wa"}, 64'(bus.b0_wa_o), 64'(a0));
        check({tag, "_b0wd"}, 64'(bus.b0_wd_o), 64'(d0));
        check({tag, "_b1we"}, 64'(bus.b1_we_o), 64'(we1));
        check({tag, "_b1wa"}, 64'(bus.b1_wa_o), 64'(a1));
        check({tag, "_b1wd"}, 64'(bus.b1_wd_o), 64'(d1));
    endtask

    // Called on the first cycle after rst deasserts; ends in the first RUN cycle.
    task automatic init_sweep(input string tag);
        for (int k = 0; k < 16; k++) begin
            #2;
            check_bank($sformatf("%s_clr%0d", tag, k), 1'b1, 5'(2 * k), 32'd0, 1'b1, 5'(2 * k + 1), 32'd0);
            check({tag, "_init_done_lo"}, 64'(bus.init_done_o), 64'd0);
            check({tag, "_ready_lo"}, 64'(bus.w_ready_o), 64'd0);
            tick();
        end
        #2;
        check({tag, "_init_done"}, 64'(bus.init_done_o), 64'd1);
        check({tag, "_ready"}, 64'(bus.w_ready_o), 64'd1);
        check({tag, "_idle"}, 64'(bus.idle_o), 64'd1);
        check_bank({tag, "_run_quiet"}, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.ra0_i = 5'd6; bus.ra1_i = 5'd0; bus.ra2_i = 5'd0; bus.ra3_i = 5'd0;
        repeat (2) tick();
        #2;
        check("rst_ready", 64'(bus.w_ready_o), 64'd0);
        check("rst_init_done", 64'(bus.init_done_o), 64'd0);
        check("rst_idle", 64'(bus.idle_o), 64'd0);
        check("rst_pending", 64'(bus.rd_pending_o), 64'd0);
        check("rst_conflict", 64'(bus.conflict_cnt_o), 64'd0);
        check_bank("rst_bank", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        init_sweep("init");

        // Different banks in one cycle: both bypass, nothing stored.
        tick();
        drive(1'b1, 5'd4, 32'hAAAA_0001, 1'b1, 5'd7, 32'hBBBB_0001);
        #2;
        check_bank("split", 1'b1, 5'd4, 32'hAAAA_0001, 1'b1, 5'd7, 32'hBBBB_0001);
        check("split_idle", 64'(bus.idle_o), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check("split_idle_after", 64'(bus.idle_o), 64'd1);
        check("split_conflict", 64'(bus.conflict_cnt_o), 64'd0);

        // Same address on both channels: ch0 now, ch1 next cycle.
        tick();
        drive(1'b1, 5'd6, 32'hAAAA_0002, 1'b1, 5'd6, 32'hBBBB_0002);
        #2;
        check_bank("same0", 1'b1, 5'd6, 32'hAAAA_0002, 1'b0, 5'd0, 32'd0);
        check("same0_pending", 64'(bus.rd_pending_o), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check_bank("same1", 1'b1, 5'd6, 32'hBBBB_0002, 1'b0, 5'd0, 32'd0);
        check("same1_pending", 64'(bus.rd_pending_o), 64'b0001);
        check("same1_conflict", 64'(bus.conflict_cnt_o), 64'd1);
        check("same1_idle", 64'(bus.idle_o), 64'd0);
        tick();
        #2;
        check("same2_pending", 64'(bus.rd_pending_o), 64'd0);
        check("same2_idle", 64'(bus.idle_o), 64'd1);

        // Back-to-back dual bank0 writes fill the queue and drop ready.
        bus.ra1_i = 5'd8; bus.ra2_i = 5'd10;
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
        #2;
        check_bank("bp0", 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        check("bp0_ready", 64'(bus.w_ready_o), 64'd1);
        tick();
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'h1010);
        #2;
        check_bank("bp1", 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
        check("bp1_ready", 64'(bus.w_ready_o), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check_bank("bp2", 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0);
        check("bp2_ready", 64'(bus.w_ready_o), 64'd0);
        check("bp2_pending", 64'(bus.rd_pending_o), 64'b0110);
        tick();
        #2;
        check_bank("bp3", 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0, 32'd0);
        check("bp3_ready", 64'(bus.w_ready_o), 64'd1);
        check("bp3_pending", 64'(bus.rd_pending_o), 64'b0100);
        tick();
        #2;
        check("bp4_idle", 64'(bus.idle_o), 64'd1);
        check("bp4_conflict", 64'(bus.conflict_cnt_o), 64'd3);

        // r0 writes are accepted and dropped; r0 plus a real write is no conflict.
        tick();
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        #2;
        check_bank("r0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("r0_idle", 64'(bus.idle_o), 64'd1);
        tick();
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd2, 32'h66);
        #2;
        check_bank("r0_mix", 1'b1, 5'd2, 32'h66, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check("r0_conflict", 64'(bus.conflict_cnt_o), 64'd3);

        // Reset with two entries queued in bank0: they must vanish.
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
        tick();
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'h1010);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        #2;
        check_bank("flush_rst", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("flush_ready", 64'(bus.w_ready_o), 64'd0);
        check("flush_pending", 64'(bus.rd_pending_o), 64'd0);
        check("flush_conflict", 64'(bus.conflict_cnt_o), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        init_sweep("reinit");
        check("reinit_pending", 64'(bus.rd_pending_o), 64'd0);
        check("reinit_conflict", 64'(bus.conflict_cnt_o), 64'd0);
        tick();
        #2;
        check_bank("reinit_quiet", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Alternate bank0 and bank1 conflicts so ready never drops; run past saturation.
        for (int i = 0; i < 65534; i++) begin
            if (i % 2 == 0) drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h2);
            else            drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd5, 32'h4);
            tick();
        end
        #2;
        check("sat_fffe", 64'(bus.conflict_cnt_o), 64'hFFFE);
        check("sat_ready", 64'(bus.w_ready_o), 64'd1);
        drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h2);
        tick();
        #2;
        check("sat_ffff", 64'(bus.conflict_cnt_o), 64'hFFFF);
        for (int i = 0; i < 3; i++) begin
            if (i % 2 == 0) drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd5, 32'h4);
            else            drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h2);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check("sat_hold", 64'(bus.conflict_cnt_o), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter QDEPTH, default 2, meaning per-bank write-queue depth; only 2 is supported.
REQ-003 Clock and reset SHALL be: clk  in  1  single clock, all state on posedge; rst  in  1  reset, synchronous and active-high.
REQ-004 Write channel k (k=0,1) SHALL be: wv{k}_i  in  1  write valid; wa{k}_i  in  5  register address; wd{k}_i  in  WIDTH  write data.
REQ-005 Channel ready SHALL be: w_ready_o  out  1  shared ready for both write channels.
REQ-006 Hazard ports SHALL be: ra{0..3}_i  in  5  read addresses; rd_pending_o  out  4  bit i high when ra{i}_i has a queued, unissued write.
REQ-007 Bank ports SHALL be: b{0,1}_we_o  out  1; b{0,1}_wa_o  out  5; b{0,1}_wd_o  out  WIDTH; bank0 serves even addresses, bank1 serves odd.
REQ-008 Status ports SHALL be: init_done_o  out  1  clear sequence finished; idle_o  out  1  both queues empty and no issue this cycle; conflict_cnt_o  out  16  same-bank dual-write cycle count.

Function
REQ-009 The FSM SHALL have states INIT and RUN; rst forces INIT with a 4-bit clear counter cnt=0.
REQ-010 In INIT, each cycle SHALL drive b0_we_o=1, b0_wa_o={cnt,0}, b1_we_o=1, b1_wa_o={cnt,1}, both wd=0, and then increment cnt.
REQ-011 The transition INIT->RUN SHALL occur after the cycle with cnt=15, i.e. 16 cycles after rst deasserts; init_done_o SHALL be 1 exactly in RUN.
REQ-012 w_ready_o SHALL be 1 only in RUN with occ0<=1 and occ1<=1, where occ = stored queue entries; it SHALL NOT depend on wv/wa.
REQ-013 fire_k = wv{k}_i & w_ready_o; a fired write with wa=0 SHALL be accepted and discarded (r0 is hardwired zero).
REQ-014 A fired nonzero write SHALL go to bank wa[0]; when both fire to one bank, channel 0 SHALL be ordered before channel 1.
REQ-015 Each bank SHALL issue at most one write per cycle, the oldest of {stored entries, then this cycle's fired writes}; zero-latency bypass SHALL apply when the queue is empty.
REQ-016 Unissued writes SHALL be stored in order; occ_next = occ + n_in - issued, never exceeding 2.
REQ-017 Two writes to the same address SHALL both reach the bank in order, so that channel 1's data ends up in the register.
REQ-018 rd_pending_o[i] SHALL be 1 iff ra{i}_i != 0 and it equals the address of any stored entry; this is combinational from the registered queue only.
REQ-019 conflict_cnt_o SHALL increment when both fire with nonzero, same-parity addresses, and SHALL saturate at 16'hFFFF.
REQ-020 In RUN with nothing to issue, b*_we_o SHALL be 0 and b*_wa_o/b*_wd_o SHALL be 0.

Reset
REQ-021 While rst=1: w_ready_o=0, init_done_o=0, idle_o=0, rd_pending_o=0, conflict_cnt_o=0, queues empty, b*_we_o=0.
REQ-022 rst asserted mid-INIT or mid-RUN SHALL flush queued writes without issuing them and restart INIT from cnt=0 after deassertion.

Verification
REQ-023 Release rst -> for 16 cycles b0 writes 0,2,..,30 and b1 writes 1,3,..,31 with data 0; then init_done_o=1 and w_ready_o=1.
REQ-024 RUN, wa0=4 wd0=A, wa1=7 wd1=B, same cycle -> same cycle b0 writes (4,A) and b1 writes (7,B); occ stays 0; conflict_cnt_o unchanged.
REQ-025 RUN, wa0=6 wd0=A, wa1=6 wd1=B -> b0 writes (6,A) this cycle and (6,B) next cycle; rd_pending for ra=6 is 1 for one cycle; conflict_cnt_o=1.
REQ-026 Two back-to-back cycles of dual bank0 writes (2,4),(8,10) -> w_ready_o drops to 0 once occ0=2, writes issue 2,4,8,10 one per cycle, and no write is lost or reordered.
REQ-027 wa0=0 with wv0=1, and 0xFFFF+3 conflict cycles -> no bank write for r0; conflict_cnt_o holds at 16'hFFFF.
REQ-028 rst pulsed with occ0=2 -> queued writes are never issued and INIT restarts at cnt=0.
